// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder: codes are queued in a FIFO and each one is driven as a
// one-hot select for HOLD enabled cycles, back-to-back with no idle gap.
module decoder_3x8_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  input  logic                     en,
  output logic [7:0]               O,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic [7:0]      r_o, w_o_nxt;
  logic            r_out_valid;
  logic            w_push, w_pop;
  logic [7:0]      w_onehot;

  // Ready looks only at occupancy, so a full FIFO rejects even during a pop.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign w_push    = in_valid & in_ready;
  assign w_onehot  = 8'(8'b1 << r_mem[r_rptr]);

  assign O         = r_o;
  assign out_valid = r_out_valid;
  assign count     = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_o_nxt     = r_o;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_o_nxt = 8'h00;
        if (en && r_count != '0) begin
          w_pop       = 1'b1;
          w_o_nxt     = w_onehot;
          w_hold_nxt  = HW'(HOLD - 1);
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (en) begin
          if (r_hold != '0) begin
            w_hold_nxt = r_hold - HW'(1);
          end else if (r_count != '0) begin
            // Reload straight from the head so the output never drops to zero.
            w_pop      = 1'b1;
            w_o_nxt    = w_onehot;
            w_hold_nxt = HW'(HOLD - 1);
          end else begin
            w_o_nxt     = 8'h00;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_o_nxt     = 8'h00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_hold      <= '0;
      r_o         <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_hold      <= w_hold_nxt;
      r_o         <= w_o_nxt;
      r_out_valid <= |w_o_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_code;
  end

endmodule
